// File: rtl/inj_pkg.sv
// Shared types and output-off constants for the peak-and-hold injector bank.
package inj_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEAK  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } inj_state_t;

  localparam logic SET_OFF     = 1'b0;
  localparam logic RESET_OFF   = 1'b1;
  localparam logic FLYBACK_OFF = 1'b0;

endpackage

// File: rtl/injector_ph_channel.sv
// One peak-and-hold injector channel: FSM, optional peak-timeout counter and
// registered drive outputs. Peak timeout/FAULT built only with INJ_PEAK_TIMEOUT_EN.
module injector_ph_channel
  import inj_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             peak,
  input  logic             hold,
  input  logic             tick,
  input  logic [CNT_W-1:0] peak_timeout,
  output logic             set,
  output logic             reset,
  output logic             flyback,
  output logic             fault
);

  inj_state_t state, state_nxt;
  logic       set_nxt, reset_nxt, flyback_nxt;

`ifdef INJ_PEAK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] pcnt, pcnt_nxt;
  logic             timeout_hit;
  logic             fault_nxt;

  assign timeout_hit = (peak_timeout != '0) && (pcnt == peak_timeout - ONE);
`else
  logic unused_timeout;
  assign unused_timeout = ^peak_timeout;
  assign fault = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
`ifdef INJ_PEAK_TIMEOUT_EN
    pcnt_nxt  = pcnt;
`endif
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = PEAK;
`ifdef INJ_PEAK_TIMEOUT_EN
          pcnt_nxt  = '0;
`endif
        end
      end
      PEAK: begin
        if (!enable)    state_nxt = IDLE;
        else if (peak)  state_nxt = HOLD;
`ifdef INJ_PEAK_TIMEOUT_EN
        else if (timeout_hit) state_nxt = FAULT;
        else if (pcnt != '1)  pcnt_nxt = pcnt + ONE;
`endif
      end
      HOLD: begin
        if (!enable) state_nxt = IDLE;
      end
`ifdef INJ_PEAK_TIMEOUT_EN
      FAULT: begin
        if (!enable) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as the FSM.
  always_comb begin
    set_nxt     = SET_OFF;
    reset_nxt   = RESET_OFF;
    flyback_nxt = FLYBACK_OFF;
`ifdef INJ_PEAK_TIMEOUT_EN
    fault_nxt   = 1'b0;
`endif
    case (state_nxt)
      PEAK: begin
        set_nxt   = 1'b1;
        reset_nxt = 1'b0;
      end
      HOLD: begin
        flyback_nxt = 1'b1;
        reset_nxt   = hold;
        set_nxt     = tick & ~hold;
      end
`ifdef INJ_PEAK_TIMEOUT_EN
      FAULT: fault_nxt = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      set     <= SET_OFF;
      reset   <= RESET_OFF;
      flyback <= FLYBACK_OFF;
`ifdef INJ_PEAK_TIMEOUT_EN
      fault   <= 1'b0;
      pcnt    <= '0;
`endif
    end else begin
      state   <= state_nxt;
      set     <= set_nxt;
      reset   <= reset_nxt;
      flyback <= flyback_nxt;
`ifdef INJ_PEAK_TIMEOUT_EN
      fault   <= fault_nxt;
      pcnt    <= pcnt_nxt;
`endif
    end
  end

endmodule

// File: rtl/injector_ph_bank.sv
// N_CH-channel peak-and-hold injector bank with a shared hold-PWM period counter.
// Peak timeout / FAULT handling is compiled in with INJ_PEAK_TIMEOUT_EN.
module injector_ph_bank
  import inj_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_CH-1:0]  i_enable,
  input  logic [N_CH-1:0]  i_peak,
  input  logic [N_CH-1:0]  i_hold,
  input  logic [CNT_W-1:0] i_hold_period,
  input  logic [CNT_W-1:0] i_peak_timeout,
  output logic [N_CH-1:0]  o_set,
  output logic [N_CH-1:0]  o_reset,
  output logic [N_CH-1:0]  o_flyback,
  output logic [N_CH-1:0]  o_fault
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = (i_hold_period != '0) && (cnt == '0);

  // A shrunk period that the count already exceeds wraps straight back to zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      cnt <= '0;
    else if ((i_hold_period == '0) || (cnt >= i_hold_period - ONE))
      cnt <= '0;
    else
      cnt <= cnt + ONE;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    injector_ph_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk          (i_clk),
      .rst          (i_rst),
      .enable       (i_enable[g]),
      .peak         (i_peak[g]),
      .hold         (i_hold[g]),
      .tick         (tick),
      .peak_timeout (i_peak_timeout),
      .set          (o_set[g]),
      .reset        (o_reset[g]),
      .flyback      (o_flyback[g]),
      .fault        (o_fault[g])
    );
  end

endmodule

// File: tb/tb_injector_ph_bank.sv
// Bench for injector_ph_bank: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the bank.
module tb_injector_ph_bank;

`ifdef INJ_PEAK_TIMEOUT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en, pk, hd;
  logic [15:0] per, tmo;
  logic [3:0]  o_set, o_reset, o_flyback, o_fault;

  injector_ph_bank #(.N_CH(4), .CNT_W(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (en),
    .i_peak         (pk),
    .i_hold         (hd),
    .i_hold_period  (per),
    .i_peak_timeout (tmo),
    .o_set          (o_set),
    .o_reset        (o_reset),
    .o_flyback      (o_flyback),
    .o_fault        (o_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: mode 0=off,1=peak,2=hold,3=fault; peak_age = cycles spent in peak.
  int mode [4];
  int peak_age [4];
  int phase;
  logic [3:0] e_set, e_reset, e_fly, e_fault;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_set"},     o_set,     e_set);
    check({tag, "_reset"},   o_reset,   e_reset);
    check({tag, "_flyback"}, o_flyback, e_fly);
    check({tag, "_fault"},   o_fault,   e_fault);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      mode[c] = 0;
      peak_age[c] = 0;
    end
    phase   = 0;
    e_set   = 4'b0000;
    e_reset = 4'b1111;
    e_fly   = 4'b0000;
    e_fault = 4'b0000;
  endtask

  task automatic model_step();
    bit tick;
    tick = (per != 0) && (phase == 0);
    for (int c = 0; c < 4; c++) begin
      case (mode[c])
        0: if (en[c]) begin mode[c] = 1; peak_age[c] = 0; end
        1: begin
          if (!en[c]) mode[c] = 0;
          else if (pk[c]) mode[c] = 2;
          else if (FEAT && tmo != 0 && peak_age[c] + 1 == int'(tmo)) mode[c] = 3;
          else if (peak_age[c] < 65535) peak_age[c]++;
        end
        default: if (!en[c]) mode[c] = 0;
      endcase
      e_set[c] = 1'b0; e_reset[c] = 1'b1; e_fly[c] = 1'b0; e_fault[c] = 1'b0;
      case (mode[c])
        1: begin e_set[c] = 1'b1; e_reset[c] = 1'b0; end
        2: begin e_fly[c] = 1'b1; e_reset[c] = hd[c]; e_set[c] = tick && !hd[c]; end
        3: e_fault[c] = 1'b1;
        default: ;
      endcase
    end
    if (per == 0 || phase + 1 >= int'(per)) phase = 0;
    else phase = phase + 1;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = '0; pk = '0; hd = '0; per = '0; tmo = '0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // ch0 into HOLD, then asynchronous reset mid-hold
    per = 16'd10;
    en = 4'b0001; cycle("ch0_peak");
    pk = 4'b0001; cycle("ch0_enter_hold");
    pk = '0;
    repeat (5) cycle("ch0_hold");
    async_reset("async_rst");
    en = '0;
    repeat (3) cycle("post_rst_idle");

    // ch1 peak pulse at cycle 5, then hold PWM with random hold comparator
    en = 4'b0010;
    repeat (5) cycle("ch1_peak");
    pk = 4'b0010; cycle("ch1_enter_hold");
    pk = '0;
    for (int i = 0; i < 40; i++) begin
      hd = ($urandom_range(0, 3) == 0) ? 4'b0010 : 4'b0000;
      cycle("ch1_hold_pwm");
    end
    hd = 4'b0010;
    repeat (12) cycle("tick_and_hold");
    hd = '0; en = '0;
    cycle("ch1_off");

    // peak timeout of 20 on ch2
    tmo = 16'd20;
    en = 4'b0100;
    repeat (25) cycle("ch2_timeout");
    check("fault_sticky", o_fault, FEAT ? 4'b0100 : 4'b0000);
    en = '0;
    cycle("ch2_release");
    check("fault_clear", o_fault, 4'b0000);
    cycle("ch2_idle");

    // i_peak on exactly the timeout cycle wins on ch3
    en = 4'b1000;
    cycle("ch3_enter_peak");
    repeat (19) cycle("ch3_peak");
    pk = 4'b1000; cycle("ch3_peak_vs_timeout");
    pk = '0;
    check("peak_wins_fault", o_fault, 4'b0000);
    check("peak_wins_fly", o_flyback, 4'b1000);
    repeat (4) cycle("ch3_hold");
    en = '0; cycle("ch3_off");

    // long PEAK dwell on ch0
    en = 4'b0001;
    repeat (1000) cycle("long_peak");
    check("long_peak_fault", o_fault, FEAT ? 4'b0001 : 4'b0000);
    check("long_peak_set", o_set, FEAT ? 4'b0000 : 4'b0001);
    en = '0; cycle("long_peak_off");

    // staggered starts on all channels, period shrinks 100 -> 3 at count 50
    tmo = '0; per = 16'd100;
    for (int i = 0; i < 300; i++) begin
      if (i == 3)  en[0] = 1'b1;
      if (i == 7)  en[1] = 1'b1;
      if (i == 11) en[2] = 1'b1;
      if (i == 15) en[3] = 1'b1;
      pk = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      hd = 4'($urandom_range(0, 15));
      if (i > 20 && per == 16'd100 && phase == 50) per = 16'd3;
      cycle("stagger");
    end
    en = '0; pk = '0; hd = '0;
    cycle("stagger_off");

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 4))
          0: per = 16'd0;
          1: per = 16'd1;
          2: per = 16'd2;
          3: per = 16'd5;
          default: per = 16'd7;
        endcase
      end
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 3))
          0: tmo = 16'd0;
          1: tmo = 16'd1;
          2: tmo = 16'd3;
          default: tmo = 16'd8;
        endcase
      end
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
        pk[c] = ($urandom_range(0, 7) == 0);
        hd[c] = ($urandom_range(0, 2) == 0);
      end
      cycle("random");
      if ($urandom_range(0, 199) == 0) async_reset("random_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
